// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/DIV sequencer owning HI/LO for the E stage.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   op_valid, op     E-stage mul/div-class op (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO)
//   src_a, src_b     forwarded rs/rt operands
//   d_muldiv         D-stage instruction is mul/div-class
//   busy, start      operation in progress / accepted this cycle
//   stall_req        freeze F/D and bubble E
//   rd_data          MFHI/MFLO read data
//   hi, lo           architectural HI/LO registers
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_muldiv,
    output logic        busy,
    output logic        start,
    output logic        stall_req,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXN = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXN + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, nextState;
    logic [CW-1:0] cnt, nextCnt;
    logic [31:0] pendHi, pendLo;
    logic pendWr;
    logic [63:0] prodS, prodU, result;
    logic [31:0] divA, divB, uQuo, uRem, quo, rem;
    logic isSigned, commit;

    // Signed divide is done on magnitudes and fixed up afterwards, which also
    // gives 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        isSigned = op == 3'd2;
        divA = isSigned && src_a[31] ? -src_a : src_a;
        divB = isSigned && src_b[31] ? -src_b : src_b;
        uQuo = divB == '0 ? '0 : divA / divB;
        uRem = divB == '0 ? '0 : divA % divB;
        quo = isSigned && (src_a[31] ^ src_b[31]) ? -uQuo : uQuo;
        rem = isSigned && src_a[31] ? -uRem : uRem;
        prodS = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prodU = {32'd0, src_a} * {32'd0, src_b};
        result = op[1] ? {rem, quo} : (op[0] ? prodU : prodS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            pendHi <= '0;
            pendLo <= '0;
            pendWr <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (start) begin
                pendHi <= result[63:32];
                pendLo <= result[31:0];
                pendWr <= !(op[1] && src_b == '0);
            end
            if (commit)
                hi <= pendHi;
            else if (op_valid && state == IDLE && op == 3'd4)
                hi <= src_a;
            if (commit)
                lo <= pendLo;
            else if (op_valid && state == IDLE && op == 3'd5)
                lo <= src_a;
        end
    end

    always_comb begin
        nextState = state == RUN ? (cnt == CW'(1) ? IDLE : RUN) : (start ? RUN : IDLE);
        nextCnt = state == RUN ? cnt - 1'b1 : (start ? (op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) : cnt);
    end

    always_comb begin
        busy = state == RUN;
        start = op_valid && !op[2] && state == IDLE;
        stall_req = d_muldiv && (busy || start);
        commit = state == RUN && cnt == CW'(1) && pendWr;
        rd_data = op == 3'd6 ? hi : (op == 3'd7 ? lo : '0);
    end

    // Hazard logic must never present an op while an operation is running.
    always_ff @(posedge clk)
        if (!reset) assert (!(op_valid && busy));
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from E and owns the HI/LO registers.
- Counts the configured latency, holds `busy`, and raises a stall request so the D-stage hazard logic can freeze any later mul/div-class instruction until the result commits.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  E-stage instruction is a mul/div-class op this cycle.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MFHI 7=MFLO.
- src_a  in  32  forwarded rs value (E).
- src_b  in  32  forwarded rt value (E).
- d_muldiv  in  1  D-stage instruction is mul/div-class.
- busy  out  1  arithmetic operation in progress.
- start  out  1  arithmetic op accepted this cycle (combinational).
- stall_req  out  1  freeze F/D, bubble E.
- rd_data  out  32  MFHI/MFLO result for the E→M register.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: state=IDLE, cnt=0, hi=0, lo=0, busy=0. All pending registers cleared.
- start = op_valid & op<4 & state==IDLE.
- stall_req = d_muldiv & (busy | start).
- States:
  - IDLE.
  - RUN: cnt counts down from N to 1.
- IDLE→RUN on start:
  - Latch the 64-bit result into pend_hi/pend_lo at that edge.
  - N = MULT_CYCLES for op 0/1, N = DIV_CYCLES for op 2/3.
  - cnt=N.
- RUN:
  - busy=1 for exactly N cycles after the accepting edge.
  - cnt decrements each cycle.
  - On the edge where cnt==1: hi←pend_hi, lo←pend_lo, state→IDLE, busy falls the same edge.
  - New HI/LO values are visible the cycle busy is first 0.
- Arithmetic:
  - MULT: signed 32x32→64, hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32→64, same split.
  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (src_b==0): operation still runs N cycles, but hi/lo are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO (op 4/5, op_valid, state==IDLE): write src_a to hi/lo at the edge, zero latency, busy stays 0.
- MFHI/MFLO: rd_data = hi or lo combinationally. rd_data=0 for any other op.
- Same-edge MTxx followed by MFxx: MFxx in the next cycle returns the newly written value. No internal bypass is needed.
- op_valid with state==RUN:
  - The op is ignored, including MTxx and new starts; hi/lo are not modified.
  - This is an illegal sequence because stall_req prevents it.
  - Assertion in sim: op_valid & busy is an error.
- reset during RUN: takes priority, aborts immediately, pending result discarded, all outputs return to reset values next cycle.
- Back-to-back ops:
  - A new start is accepted in the first cycle with busy=0, i.e. the cycle after commit.
  - Minimum spacing is N+1 edges between starts.

Test Plan:
- Signed multiply: reset; MULT src_a=0xFFFFFFFE (-2), src_b=3 → busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MFLO next cycle rd_data=0xFFFFFFFA.
- Signed/unsigned divide:
  - DIV src_a=0xFFFFFFF9 (-7), src_b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU same operands → lo=0x7FFFFFFC, hi=1.
- Stall request: MULT started while d_muldiv=1 → stall_req=1 on the start cycle and all 5 busy cycles, 0 the cycle busy drops; with d_muldiv=0, stall_req stays 0 throughout.
- Divide by zero and overflow:
  - MTHI 0x1234, MTLO 0x5678, then DIV by 0 → after 10 cycles hi=0x1234, lo=0x5678.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Reset abort: reset asserted in the 3rd busy cycle of MULTU 0xFFFFFFFF×0xFFFFFFFF → next cycle busy=0, hi=lo=0; no later commit of 0xFFFFFFFE/0x00000001.
- Back-to-back: MULT 2×3 then MULTU 4×5 issued the first cycle busy=0 → lo=6, then 6 cycles later lo=20, hi=0.
